// File: rtl/ld_backend_addr_gen.sv
// Two-level (inner/outer) read address generator for the load back-end.
// Issues one address per unstalled cycle and pulses O_Term_AddrGen after the last one.
module ld_backend_addr_gen #(
  parameter int WIDTH_ADDR = 16,
  parameter int WIDTH_LEN  = 12
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  I_Start,
  input  logic                  I_Stall,
  input  logic                  I_Abort,
  input  logic [WIDTH_ADDR-1:0] I_Base,
  input  logic [WIDTH_ADDR-1:0] I_Stride,
  input  logic [WIDTH_LEN-1:0]  I_Length,
  input  logic [WIDTH_LEN-1:0]  I_Repeat,
  input  logic [WIDTH_ADDR-1:0] I_Skip,
  output logic                  O_Req,
  output logic [WIDTH_ADDR-1:0] O_Addr,
  output logic                  O_Busy,
  output logic                  O_Term_AddrGen
);

  typedef enum logic [1:0] {
    AGU_IDLE = 2'd0,
    AGU_RUN  = 2'd1,
    AGU_TERM = 2'd2
  } agu_state_e;

  localparam logic [WIDTH_ADDR-1:0] ADDR_ZERO = {WIDTH_ADDR{1'b0}};
  localparam logic [WIDTH_LEN-1:0]  LEN_ZERO  = {WIDTH_LEN{1'b0}};
  localparam logic [WIDTH_LEN-1:0]  LEN_ONE   = {{(WIDTH_LEN-1){1'b0}}, 1'b1};

  agu_state_e            state_q, state_d;
  logic [WIDTH_ADDR-1:0] addr_q, addr_d;
  logic [WIDTH_ADDR-1:0] row_base_q, row_base_d;
  logic [WIDTH_ADDR-1:0] stride_q, stride_d;
  logic [WIDTH_ADDR-1:0] skip_q, skip_d;
  logic [WIDTH_LEN-1:0]  in_cnt_q, in_cnt_d;
  logic [WIDTH_LEN-1:0]  out_cnt_q, out_cnt_d;
  logic [WIDTH_LEN-1:0]  len_m1_q, len_m1_d;
  logic [WIDTH_LEN-1:0]  rep_m1_q, rep_m1_d;
  logic                  req_s;
  logic                  term_s;

  // State and configuration registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= AGU_IDLE;
      addr_q     <= ADDR_ZERO;
      row_base_q <= ADDR_ZERO;
      stride_q   <= ADDR_ZERO;
      skip_q     <= ADDR_ZERO;
      in_cnt_q   <= LEN_ZERO;
      out_cnt_q  <= LEN_ZERO;
      len_m1_q   <= LEN_ZERO;
      rep_m1_q   <= LEN_ZERO;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      row_base_q <= row_base_d;
      stride_q   <= stride_d;
      skip_q     <= skip_d;
      in_cnt_q   <= in_cnt_d;
      out_cnt_q  <= out_cnt_d;
      len_m1_q   <= len_m1_d;
      rep_m1_q   <= rep_m1_d;
    end
  end

  // Next-state, address stepping and request/term generation.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    row_base_d = row_base_q;
    stride_d   = stride_q;
    skip_d     = skip_q;
    in_cnt_d   = in_cnt_q;
    out_cnt_d  = out_cnt_q;
    len_m1_d   = len_m1_q;
    rep_m1_d   = rep_m1_q;
    req_s      = 1'b0;
    term_s     = 1'b0;

    case (state_q)
      AGU_IDLE: begin
        // Start beats a simultaneous abort because abort is only honoured when busy.
        if (I_Start) begin
          addr_d     = I_Base;
          row_base_d = I_Base;
          stride_d   = I_Stride;
          skip_d     = I_Skip;
          in_cnt_d   = LEN_ZERO;
          out_cnt_d  = LEN_ZERO;
          len_m1_d   = I_Length - LEN_ONE;
          rep_m1_d   = I_Repeat - LEN_ONE;
          if ((I_Length == LEN_ZERO) || (I_Repeat == LEN_ZERO)) begin
            state_d = AGU_TERM;
          end else begin
            state_d = AGU_RUN;
          end
        end else begin
          state_d = AGU_IDLE;
        end
      end

      AGU_RUN: begin
        if (I_Abort) begin
          state_d = AGU_IDLE;
        end else if (!I_Stall) begin
          req_s = 1'b1;
          if (in_cnt_q != len_m1_q) begin
            addr_d   = addr_q + stride_q;
            in_cnt_d = in_cnt_q + LEN_ONE;
          end else if (out_cnt_q != rep_m1_q) begin
            row_base_d = row_base_q + skip_q;
            addr_d     = row_base_q + skip_q;
            in_cnt_d   = LEN_ZERO;
            out_cnt_d  = out_cnt_q + LEN_ONE;
          end else begin
            state_d = AGU_TERM;
          end
        end else begin
          state_d = AGU_RUN;
        end
      end

      AGU_TERM: begin
        state_d = AGU_IDLE;
        if (I_Abort) begin
          term_s = 1'b0;
        end else begin
          term_s = 1'b1;
        end
      end

      default: begin
        state_d = AGU_IDLE;
      end
    endcase
  end

  assign O_Req          = req_s;
  assign O_Addr         = addr_q;
  assign O_Busy         = (state_q != AGU_IDLE);
  assign O_Term_AddrGen = term_s;

endmodule

// File: tb/tb_ld_backend_addr_gen.sv
// Self-checking bench for ld_backend_addr_gen: directed table, corner sequences,
// and randomized patterns against a nested-loop address model.
module tb_ld_backend_addr_gen;

  logic        clock;
  logic        reset;
  logic        I_Start, I_Stall, I_Abort;
  logic [15:0] I_Base, I_Stride, I_Skip;
  logic [11:0] I_Length, I_Repeat;
  logic        O_Req, O_Busy, O_Term_AddrGen;
  logic [15:0] O_Addr;

  int tests_run = 0;
  int tests_failed = 0;

  ld_backend_addr_gen #(.WIDTH_ADDR(16), .WIDTH_LEN(12)) dut (
    .clock(clock), .reset(reset),
    .I_Start(I_Start), .I_Stall(I_Stall), .I_Abort(I_Abort),
    .I_Base(I_Base), .I_Stride(I_Stride), .I_Length(I_Length),
    .I_Repeat(I_Repeat), .I_Skip(I_Skip),
    .O_Req(O_Req), .O_Addr(O_Addr), .O_Busy(O_Busy), .O_Term_AddrGen(O_Term_AddrGen)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [15:0]      base;
    logic [15:0]      stride;
    logic [11:0]      len;
    logic [11:0]      rep;
    logic [15:0]      skip;
    logic [15:0]      stall;     // bit c = stall on the c-th cycle after start
    int               n_req;
    int               term_cyc;
    logic [7:0][15:0] a;         // a[0] is the first expected address
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic start(input logic [15:0] base, input logic [15:0] stride,
                       input logic [11:0] len, input logic [11:0] rep, input logic [15:0] skip);
    @(negedge clock);
    I_Base = base; I_Stride = stride; I_Length = len; I_Repeat = rep; I_Skip = skip;
    I_Start = 1'b1; I_Stall = 1'b0; I_Abort = 1'b0;
    @(negedge clock);
    I_Start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int k;
    k = 0;
    start(v.base, v.stride, v.len, v.rep, v.skip);
    for (int c = 0; c < 16; c++) begin
      I_Stall = v.stall[c];
      #1;
      check("vec_req", {31'd0, O_Req}, {31'd0, (k < v.n_req) && !v.stall[c]});
      check("vec_term", {31'd0, O_Term_AddrGen}, {31'd0, c == v.term_cyc});
      check("vec_busy", {31'd0, O_Busy}, {31'd0, c <= v.term_cyc});
      if (k < v.n_req) begin
        check("vec_addr", {16'd0, O_Addr}, {16'd0, v.a[k]});
        if (!v.stall[c]) k++;
      end
      @(negedge clock);
    end
    I_Stall = 1'b0;
  endtask

  task automatic run_random(input int n_pat);
    logic [15:0] q[$];
    logic [15:0] base, stride, skip;
    logic [11:0] len, rep;
    logic        pending_term, done, exp_req;
    int          budget;
    for (int p = 0; p < n_pat; p++) begin
      base = 16'($urandom); stride = 16'($urandom); skip = 16'($urandom);
      len = 12'($urandom_range(0, 5)); rep = 12'($urandom_range(0, 4));
      q.delete();
      for (int r = 0; r < int'(rep); r++)
        for (int i = 0; i < int'(len); i++)
          q.push_back(16'(base + r * skip + i * stride));
      pending_term = (q.size() == 0);
      start(base, stride, len, rep, skip);
      done = 1'b0;
      budget = 0;
      while (!done && budget < 200) begin
        I_Stall = ($urandom_range(0, 9) < 3);
        // a start while busy carries junk config that must be ignored
        I_Start = ($urandom_range(0, 9) == 0);
        I_Base = 16'($urandom); I_Stride = 16'($urandom); I_Skip = 16'($urandom);
        I_Length = 12'($urandom); I_Repeat = 12'($urandom);
        #1;
        exp_req = (q.size() != 0) && !I_Stall;
        check("rnd_req", {31'd0, O_Req}, {31'd0, exp_req});
        check("rnd_term", {31'd0, O_Term_AddrGen}, {31'd0, pending_term});
        check("rnd_busy", {31'd0, O_Busy}, 32'd1);
        if (q.size() != 0) check("rnd_addr", {16'd0, O_Addr}, {16'd0, q[0]});
        if (pending_term) begin
          done = 1'b1;
        end else if (exp_req) begin
          void'(q.pop_front());
          if (q.size() == 0) pending_term = 1'b1;
        end
        budget++;
        @(negedge clock);
        I_Start = 1'b0;
      end
      check("rnd_done_in_budget", {31'd0, done}, 32'd1);
      I_Stall = 1'b0;
      #1;
      check("rnd_idle_after", {31'd0, O_Busy}, 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    I_Start = 1'b0; I_Stall = 1'b0; I_Abort = 1'b0;
    I_Base = 16'h0; I_Stride = 16'h0; I_Skip = 16'h0; I_Length = 12'h0; I_Repeat = 12'h0;

    //            base     stride  len     rep     skip     stall    n  term  addresses (a[7]..a[0])
    vecs[0] = '{16'h0100, 16'h4, 12'd3, 12'd1, 16'h0,  16'h0000, 3, 3,
                {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0108, 16'h0104, 16'h0100}};
    vecs[1] = '{16'h0000, 16'h1, 12'd2, 12'd3, 16'h10, 16'h0000, 6, 6,
                {16'h0, 16'h0, 16'h21, 16'h20, 16'h11, 16'h10, 16'h01, 16'h00}};
    vecs[2] = '{16'h0100, 16'h4, 12'd3, 12'd1, 16'h0,  16'h0002, 3, 4,
                {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0108, 16'h0104, 16'h0100}};
    vecs[3] = '{16'h0200, 16'h4, 12'd0, 12'd5, 16'h0,  16'h0000, 0, 0,
                {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}};
    vecs[4] = '{16'h0300, 16'h4, 12'd4, 12'd0, 16'h0,  16'h0000, 0, 0,
                {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}};
    vecs[5] = '{16'hFFFE, 16'h1, 12'd4, 12'd1, 16'h0,  16'h0000, 4, 4,
                {16'h0, 16'h0, 16'h0, 16'h0, 16'h0001, 16'h0000, 16'hFFFF, 16'hFFFE}};

    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    check("reset_req", {31'd0, O_Req}, 32'd0);
    check("reset_addr", {16'd0, O_Addr}, 32'd0);
    check("reset_busy", {31'd0, O_Busy}, 32'd0);
    check("reset_term", {31'd0, O_Term_AddrGen}, 32'd0);

    for (int v = 0; v < 6; v++) run_vec(vecs[v]);

    // Abort on the third request cycle of the 2x3 pattern, then restart.
    start(16'h0000, 16'h1, 12'd2, 12'd3, 16'h10);
    #1; check("abort_c0_addr", {16'd0, O_Addr}, 32'h0);
    @(negedge clock); #1; check("abort_c1_addr", {16'd0, O_Addr}, 32'h1);
    @(negedge clock);
    I_Abort = 1'b1; #1;
    check("abort_req_low", {31'd0, O_Req}, 32'd0);
    check("abort_no_term", {31'd0, O_Term_AddrGen}, 32'd0);
    @(negedge clock);
    I_Abort = 1'b0; #1;
    check("abort_idle_busy", {31'd0, O_Busy}, 32'd0);
    check("abort_idle_req", {31'd0, O_Req}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock); #1;
      check("abort_never_term", {31'd0, O_Term_AddrGen}, 32'd0);
    end
    start(16'h0500, 16'h2, 12'd1, 12'd1, 16'h0);
    #1;
    check("restart_req", {31'd0, O_Req}, 32'd1);
    check("restart_addr", {16'd0, O_Addr}, 32'h0500);
    @(negedge clock); #1;
    check("restart_term", {31'd0, O_Term_AddrGen}, 32'd1);

    // Abort while in the term state suppresses the pulse.
    start(16'h0600, 16'h1, 12'd0, 12'd1, 16'h0);
    I_Abort = 1'b1; #1;
    check("abort_term_busy", {31'd0, O_Busy}, 32'd1);
    check("abort_term_nopulse", {31'd0, O_Term_AddrGen}, 32'd0);
    @(negedge clock);
    I_Abort = 1'b0; #1;
    check("abort_term_idle", {31'd0, O_Busy}, 32'd0);

    // Start together with abort while idle: start wins.
    @(negedge clock);
    I_Base = 16'h0077; I_Stride = 16'h1; I_Length = 12'd1; I_Repeat = 12'd1; I_Skip = 16'h0;
    I_Start = 1'b1; I_Abort = 1'b1;
    @(negedge clock);
    I_Start = 1'b0; I_Abort = 1'b0; #1;
    check("start_abort_req", {31'd0, O_Req}, 32'd1);
    check("start_abort_addr", {16'd0, O_Addr}, 32'h0077);
    @(negedge clock); #1;
    check("start_abort_term", {31'd0, O_Term_AddrGen}, 32'd1);

    // Reset in the middle of a run.
    start(16'h0100, 16'h4, 12'd3, 12'd1, 16'h0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock); #1;
    check("midreset_req", {31'd0, O_Req}, 32'd0);
    check("midreset_addr", {16'd0, O_Addr}, 32'h0);
    check("midreset_busy", {31'd0, O_Busy}, 32'd0);
    check("midreset_term", {31'd0, O_Term_AddrGen}, 32'd0);
    reset = 1'b0;
    @(negedge clock); #1;
    check("midreset_stays_idle", {31'd0, O_Busy}, 32'd0);

    run_random(60);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
